// File: rtl/sm1118_color_sensor_model.sv
// Behavioural stand-in for a light-to-frequency colour sensor: a prescaled half-period
// counter per filter channel drives a square wave, with runtime-writable half-periods.
module sm1118_color_sensor_model #(
  parameter logic [11:0] DEF_RED   = 12'd40,
  parameter logic [11:0] DEF_GREEN = 12'd30,
  parameter logic [11:0] DEF_BLUE  = 12'd20,
  parameter logic [11:0] DEF_CLEAR = 12'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        S0,
  input  logic        S1,
  input  logic        S2,
  input  logic        S3,
  input  logic        OE,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [11:0] cfg_data,
  output logic        cs_out,
  output logic        cs_oe,
  output logic [15:0] edge_count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [3:0]  sel_now;
  logic [3:0]  sel_q;
  logic        restart;
  logic [5:0]  div_n;
  logic [5:0]  pre_cnt;
  logic [11:0] hp_cnt;
  logic [11:0] h_q;
  logic [11:0] ch_q [4];
  logic        tog_q;
  logic        powered;
  logic        tick;
  logic        hp_done;

  assign sel_now = {S0, S1, S2, S3};
  assign restart = (sel_now != sel_q);

  always_comb begin
    div_n = 6'd0;
    case (sel_now[3:2])
      2'b01:   div_n = 6'd50;
      2'b10:   div_n = 6'd5;
      2'b11:   div_n = 6'd1;
      default: div_n = 6'd0;
    endcase
  end

  assign powered = (sel_now[3:2] != 2'b00) && (h_q != 12'd0);
  assign tick    = (pre_cnt == div_n - 6'd1);
  assign hp_done = (hp_cnt == h_q - 12'd1);

  // Channel half-period registers, indexed by the {S2,S3} filter code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q[0] <= DEF_RED;
      ch_q[1] <= DEF_BLUE;
      ch_q[2] <= DEF_CLEAR;
      ch_q[3] <= DEF_GREEN;
    end else if (cfg_we) begin
      ch_q[cfg_sel] <= cfg_data;
    end
  end

  // H is sampled from the register value before any same-edge write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 4'b0000;
      pre_cnt    <= 6'd0;
      hp_cnt     <= 12'd0;
      h_q        <= DEF_RED;
      tog_q      <= 1'b0;
      edge_count <= 16'd0;
      cs_oe      <= 1'b0;
    end else begin
      sel_q <= sel_now;
      cs_oe <= ~OE & (S0 | S1);
      if (restart) begin
        pre_cnt    <= 6'd0;
        hp_cnt     <= 12'd0;
        tog_q      <= 1'b0;
        edge_count <= 16'd0;
        h_q        <= ch_q[sel_now[1:0]];
      end else if (!powered) begin
        pre_cnt <= 6'd0;
        hp_cnt  <= 12'd0;
        tog_q   <= 1'b0;
      end else begin
        pre_cnt <= tick ? 6'd0 : pre_cnt + 6'd1;
        if (tick) begin
          if (hp_done) begin
            hp_cnt <= 12'd0;
            tog_q  <= ~tog_q;
            h_q    <= ch_q[sel_now[1:0]];
            if (!tog_q) edge_count <= sat_inc(edge_count);
          end else begin
            hp_cnt <= hp_cnt + 12'd1;
          end
        end
      end
    end
  end

  // The toggle phase keeps running while the pin is released
  assign cs_out = tog_q & cs_oe;

endmodule

// File: tb/tb_sm1118_color_sensor_model.sv
// Directed bench for the colour sensor model: an event-scheduled reference model
// is checked every cycle, plus hand-computed waveform points for each scenario.
module tb_sm1118_color_sensor_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
  logic        OE = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'b00;
  logic [11:0] cfg_data = 12'd0;
  logic        cs_out;
  logic        cs_oe;
  logic [15:0] edge_count;

  int total = 0;
  int bad = 0;

  sm1118_color_sensor_model dut (
    .clk(clk), .rst_n(rst_n), .S0(S0), .S1(S1), .S2(S2), .S3(S3), .OE(OE),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cs_out(cs_out), .cs_oe(cs_oe), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the next toggle is scheduled as an absolute cycle number
  longint    cyc = 0;
  longint    m_next = -1;
  logic [3:0]  m_sel = 4'b0000;
  logic        m_level = 1'b0;
  logic        m_oe = 1'b0;
  int          m_count = 0;
  int          m_h = 0;
  int          m_ch [4];

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'b01:   return 50;
      2'b10:   return 5;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] sel;
    int n;
    cyc++;
    sel = {S0, S1, S2, S3};
    n = div_of(sel[3:2]);
    if (!rst_n) begin
      m_sel = 4'b0000; m_level = 1'b0; m_oe = 1'b0; m_count = 0; m_next = -1;
      m_ch[0] = 40; m_ch[1] = 20; m_ch[2] = 10; m_ch[3] = 30;
    end else begin
      if (sel != m_sel) begin
        m_level = 1'b0;
        m_count = 0;
        m_h = m_ch[sel[1:0]];
        m_next = (n == 0 || m_h == 0) ? -1 : cyc + longint'(m_h * n);
      end else if (m_next >= 0 && cyc == m_next) begin
        if (!m_level && m_count < 65535) m_count++;
        m_level = ~m_level;
        m_h = m_ch[sel[1:0]];
        m_next = (m_h == 0) ? -1 : cyc + longint'(m_h * n);
      end else if (m_next < 0) begin
        m_level = 1'b0;
      end
      if (cfg_we) m_ch[cfg_sel] = int'(cfg_data);
      m_oe = ~OE & (S0 | S1);
      m_sel = sel;
    end
    #2;
    check("model_cs_out", 32'(cs_out), 32'(m_level & m_oe));
    check("model_cs_oe", 32'(cs_oe), 32'(m_oe));
    check("model_edge_count", 32'(edge_count), 32'(m_count));
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_sel(input logic [3:0] s);
    {S0, S1, S2, S3} = s;
  endtask

  task automatic pin(input string name, input logic exp_out, input int exp_cnt);
    check({name, "_cs_out"}, 32'(cs_out), 32'(exp_out));
    check({name, "_edges"}, 32'(edge_count), 32'(exp_cnt));
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [11:0] v);
    cfg_we = 1'b1; cfg_sel = ch; cfg_data = v;
    step(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    step(3);
    pin("reset", 1'b0, 0);
    check("reset_cs_oe", 32'(cs_oe), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Red at full rate: 80-clock period, ten rises within 800 clocks
    set_sel(4'b1100);
    step(40);  pin("red_pre_rise", 1'b0, 0);
    step(1);   pin("red_rise", 1'b1, 1);
    step(39);  pin("red_high_end", 1'b1, 1);
    step(1);   pin("red_fall", 1'b0, 1);
    step(719); check("red_800clk_edges", 32'(edge_count), 32'd10);

    // Blue at 20%: period 200; then 2%: restart, period 2000
    set_sel(4'b1001);
    step(100); pin("blue20_pre_rise", 1'b0, 0);
    step(1);   pin("blue20_rise", 1'b1, 1);
    step(200); pin("blue20_rise2", 1'b1, 2);
    set_sel(4'b0101);
    step(1);   pin("blue2_restart", 1'b0, 0);
    step(999); pin("blue2_pre_rise", 1'b0, 0);
    step(1);   pin("blue2_rise", 1'b1, 1);
    step(2000); pin("blue2_rise2", 1'b1, 2);

    // Green to clear mid-period
    set_sel(4'b1111);
    step(45);  pin("green_high", 1'b1, 1);
    set_sel(4'b1110);
    step(1);   pin("clear_restart", 1'b0, 0);
    step(9);   pin("clear_pre_rise", 1'b0, 0);
    step(1);   pin("clear_rise", 1'b1, 1);

    // Blue rewritten to 3 while active: finishes the 20, then 3s
    set_sel(4'b1101);
    step(5);
    cfg_write(2'b01, 12'd3);
    step(14);  pin("blue_cfg_pre_rise", 1'b0, 0);
    step(1);   pin("blue_cfg_rise", 1'b1, 1);
    step(2);   pin("blue_cfg_high", 1'b1, 1);
    step(1);   pin("blue_cfg_fall", 1'b0, 1);
    step(3);   pin("blue_cfg_rise2", 1'b1, 2);

    // Output disabled for 100 clocks, phase preserved
    set_sel(4'b1100);
    step(50);  pin("oe_before", 1'b1, 1);
    OE = 1'b1;
    step(1);   pin("oe_off", 1'b0, 1);
    check("oe_off_cs_oe", 32'(cs_oe), 32'd0);
    step(99);  check("oe_off_end", 32'(cs_out), 32'd0);
    OE = 1'b0;
    step(1);   pin("oe_back", 1'b1, 2);
    check("oe_back_cs_oe", 32'(cs_oe), 32'd1);
    step(10);  pin("oe_phase_fall", 1'b0, 2);

    // Red half-period of zero stalls after the next toggle
    cfg_write(2'b00, 12'd0);
    step(50);  pin("h0_stalled", 1'b0, 3);
    step(1000); pin("h0_1000clk", 1'b0, 3);

    // Power-down select
    set_sel(4'b0000);
    step(1);   pin("pd_restart", 1'b0, 0);
    step(1000); pin("pd_1000clk", 1'b0, 0);
    check("pd_cs_oe", 32'(cs_oe), 32'd0);

    // Reset mid-period restores defaults
    set_sel(4'b1111);
    step(45);  pin("pre_reset", 1'b1, 1);
    rst_n = 1'b0;
    step(1);   pin("in_reset", 1'b0, 0);
    check("in_reset_cs_oe", 32'(cs_oe), 32'd0);
    rst_n = 1'b1;
    step(1);
    step(29);  pin("def_green_pre", 1'b0, 0);
    step(1);   pin("def_green_rise", 1'b1, 1);
    set_sel(4'b1101);
    step(20);  pin("def_blue_pre", 1'b0, 0);
    step(1);   pin("def_blue_rise", 1'b1, 1);
    set_sel(4'b1100);
    step(40);  pin("def_red_pre", 1'b0, 0);
    step(1);   pin("def_red_rise", 1'b1, 1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
